fft_power_integrator: RTL and testbench



---
 rtl/fft_power_integrator.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_fft_power_integrator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_power_integrator.sv
// ---------------------------------------------------------------------------
// fft_power_integrator
//
// Sits behind the pipelined FFT. For each bin it computes |X|^2 = I^2 + Q^2
// and adds it into a per-bin memory over Integration_count consecutive frames.
// Every bin of the final frame of a period is presented on the output with
// its integrated power. The index, last, reverse and tag fields are taken
// from that final-frame sample.
//
// Ports
//   Clk                clock
//   Rst                synchronous, active-high reset
//   Integration_count  frames per integration period (0 behaves as 1),
//                      sampled on the first sample of each period
//   Input_control      valid / last / reverse / data_index / tag from the FFT
//   Input_i, Input_q   signed bin value
//   Output_control     control bundle of the integrated output bin
//   Output_power       integrated power (unsigned, ACCUM_WIDTH bits)
//   Error_sequence     one-cycle pulse when an input index-sequence error occurs
//
// Pipeline: register input -> squares -> sum + RAM read -> load/accumulate.
// An input sample presented in cycle n appears on the output in cycle n+4.
// A sequence error appears on Error_sequence in cycle n+1.
//
// Configuration macro: FFT_POWER_INTEGRATOR_SATURATE_EN
//   defined   - accumulation saturates at 2^ACCUM_WIDTH-1
//   undefined - accumulation wraps modulo 2^ACCUM_WIDTH
//
// The control bundle type comes from fft_power_integrator_pkg. Its index
// field width must equal INDEX_WIDTH.
// ---------------------------------------------------------------------------

package fft_power_integrator_pkg;
  localparam int FFT_INDEX_WIDTH = 5;
  localparam int FFT_TAG_WIDTH   = 8;

  typedef struct packed {
    logic                       valid;
    logic                       last;
    logic                       reverse;
    logic [FFT_INDEX_WIDTH-1:0] data_index;
    logic [FFT_TAG_WIDTH-1:0]   tag;
  } fft_control_t;
endpackage

module fft_power_integrator
  import fft_power_integrator_pkg::*;
#(
  parameter int NUM_POINTS       = 32,
  parameter int INDEX_WIDTH      = $clog2(NUM_POINTS),
  parameter int INPUT_DATA_WIDTH = 21,
  parameter int COUNT_WIDTH      = 8,
  parameter int ACCUM_WIDTH      = 2*INPUT_DATA_WIDTH + 8
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [COUNT_WIDTH-1:0]             Integration_count,
  input  fft_control_t                       Input_control,
  input  logic signed [INPUT_DATA_WIDTH-1:0] Input_i,
  input  logic signed [INPUT_DATA_WIDTH-1:0] Input_q,
  output fft_control_t                       Output_control,
  output logic [ACCUM_WIDTH-1:0]             Output_power,
  output logic                               Error_sequence
);

  localparam int SQ_WIDTH = 2*INPUT_DATA_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_POINTS-1);

  // Per-sample bookkeeping that travels with the data through the pipeline.
  // The load/accumulate and output/write-back choices are made when the
  // sample arrives, so later stages do not need to consult the FSM.
  typedef struct packed {
    logic                       last;
    logic                       reverse;
    logic [FFT_INDEX_WIDTH-1:0] data_index;
    logic [FFT_TAG_WIDTH-1:0]   tag;
    logic                       first_frame;
    logic                       final_frame;
  } meta_t;

  typedef enum logic {
    IDLE,
    INTEGRATING
  } state_t;

  state_t state;
  state_t state_next;

  logic [INDEX_WIDTH-1:0] expected_index;
  logic [COUNT_WIDTH-1:0] frame_count;
  logic [COUNT_WIDTH-1:0] target;

  logic                   index_ok;
  logic                   last_ok;
  logic                   seq_error;
  logic                   sample_ok;
  logic                   period_start;
  logic                   first_frame;
  logic                   final_frame;
  logic                   frame_end;
  logic [COUNT_WIDTH-1:0] count_eff;
  logic [COUNT_WIDTH-1:0] target_eff;
  logic [COUNT_WIDTH:0]   frames_done;

  logic                          s1_valid;
  meta_t                         s1_meta;
  logic signed [INPUT_DATA_WIDTH-1:0] s1_i;
  logic signed [INPUT_DATA_WIDTH-1:0] s1_q;

  logic                          s2_valid;
  meta_t                         s2_meta;
  logic [SQ_WIDTH-1:0]           s2_sq_i;
  logic [SQ_WIDTH-1:0]           s2_sq_q;
  logic signed [SQ_WIDTH-1:0]    ext_i;
  logic signed [SQ_WIDTH-1:0]    ext_q;

  logic                          s3_valid;
  meta_t                         s3_meta;
  logic [ACCUM_WIDTH-1:0]        s3_sum;
  logic [ACCUM_WIDTH-1:0]        rd_data;

  logic [ACCUM_WIDTH-1:0]        acc_value;

  logic [ACCUM_WIDTH-1:0]        power_mem [NUM_POINTS];

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // A sequence error abandons the period from either state. A single sample
  // cannot both open and close a frame because NUM_POINTS >= 8.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sample_ok) begin
          state_next = INTEGRATING;
        end
      end
      INTEGRATING: begin
        if (seq_error) begin
          state_next = IDLE;
        end else if (frame_end && final_frame) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM output / sample classification
  // The target for the very first sample of a period is not yet registered.
  // Therefore target_eff forwards the freshly sampled count. Without this,
  // a period with a count of 1 would miss its output on bin 0.
  // -------------------------------------------------------------------------
  always_comb begin
    count_eff    = (Integration_count == '0) ? COUNT_WIDTH'(1) : Integration_count;
    index_ok     = (Input_control.data_index == expected_index);
    last_ok      = (Input_control.last == (Input_control.data_index == LAST_INDEX));
    seq_error    = Input_control.valid && !(index_ok && last_ok);
    sample_ok    = Input_control.valid && index_ok && last_ok;
    period_start = sample_ok && (expected_index == '0) && (frame_count == '0);
    target_eff   = period_start ? count_eff : target;
    frames_done  = {1'b0, frame_count} + (COUNT_WIDTH+1)'(1);
    first_frame  = (frame_count == '0);
    final_frame  = (frames_done >= {1'b0, target_eff});
    frame_end    = sample_ok && Input_control.last;
  end

  // -------------------------------------------------------------------------
  // Sequence and frame counters, plus the latched per-period target
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      expected_index <= '0;
      frame_count    <= '0;
      target         <= COUNT_WIDTH'(1);
    end else if (seq_error) begin
      expected_index <= '0;
      frame_count    <= '0;
    end else if (sample_ok) begin
      if (period_start) begin
        target <= count_eff;
      end
      expected_index <= (expected_index == LAST_INDEX) ? '0
                                                       : expected_index + INDEX_WIDTH'(1);
      if (frame_end) begin
        frame_count <= final_frame ? '0 : frames_done[COUNT_WIDTH-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline valid bits. Only these bits are reset, which is enough to
  // discard every sample that is in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= sample_ok;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Sign-extend to full product width so each square is exact.
  always_comb begin
    ext_i = {{INPUT_DATA_WIDTH{s1_i[INPUT_DATA_WIDTH-1]}}, s1_i};
    ext_q = {{INPUT_DATA_WIDTH{s1_q[INPUT_DATA_WIDTH-1]}}, s1_q};
  end

  // -------------------------------------------------------------------------
  // Pipeline data registers and the registered RAM read. The RAM is read
  // with the stage-2 index, so the stored value arrives together with
  // stage 3's sum.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    s1_meta.last        <= Input_control.last;
    s1_meta.reverse     <= Input_control.reverse;
    s1_meta.data_index  <= Input_control.data_index;
    s1_meta.tag         <= Input_control.tag;
    s1_meta.first_frame <= first_frame;
    s1_meta.final_frame <= final_frame;
    s1_i                <= Input_i;
    s1_q                <= Input_q;

    s2_meta <= s1_meta;
    s2_sq_i <= ext_i * ext_i;
    s2_sq_q <= ext_q * ext_q;

    s3_meta <= s2_meta;
    s3_sum  <= ACCUM_WIDTH'(s2_sq_i) + ACCUM_WIDTH'(s2_sq_q);
    rd_data <= power_mem[s2_meta.data_index];
  end

  // -------------------------------------------------------------------------
  // Load on the first frame, otherwise add to the stored partial sum
  // -------------------------------------------------------------------------
`ifdef FFT_POWER_INTEGRATOR_SATURATE_EN
  logic [ACCUM_WIDTH:0] acc_wide;

  always_comb begin
    acc_wide = {1'b0, rd_data} + {1'b0, s3_sum};
    if (s3_meta.first_frame) begin
      acc_value = s3_sum;
    end else if (acc_wide[ACCUM_WIDTH]) begin
      acc_value = '1;
    end else begin
      acc_value = acc_wide[ACCUM_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    if (s3_meta.first_frame) begin
      acc_value = s3_sum;
    end else begin
      acc_value = rd_data + s3_sum;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Write back partial sums. The final frame skips the write, because the
  // next period starts by loading fresh values.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (s3_valid && !s3_meta.final_frame) begin
      power_mem[s3_meta.data_index] <= acc_value;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers. All fields read 0 whenever no bin is being presented.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Output_control <= '0;
      Output_power   <= '0;
      Error_sequence <= 1'b0;
    end else begin
      Error_sequence <= seq_error;
      if (s3_valid && s3_meta.final_frame) begin
        Output_control.valid      <= 1'b1;
        Output_control.last       <= s3_meta.last;
        Output_control.reverse    <= s3_meta.reverse;
        Output_control.data_index <= s3_meta.data_index;
        Output_control.tag        <= s3_meta.tag;
        Output_power              <= acc_value;
      end else begin
        Output_control <= '0;
        Output_power   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_power_integrator.sv
// ---------------------------------------------------------------------------
// tb_fft_power_integrator
//
// Scoreboard bench. Each issued sample goes through a behavioural model of
// the integration rules. The model holds per-bin running totals, a frame
// number and the latched period target. Any output or error the sample must
// produce is queued with the cycle it is due. A monitor on the falling edge
// pops entries and compares them whenever the DUT presents an output or an
// error pulse. During reset it checks that all outputs are zero.
// ---------------------------------------------------------------------------
module tb_fft_power_integrator;
  import fft_power_integrator_pkg::*;

  localparam int     N       = 32;
  localparam int     W       = 21;
  localparam int     AW      = 2*W + 8;
  localparam longint ACC_MOD = longint'(1) << AW;
  localparam longint ACC_MAX = ACC_MOD - 1;

  logic                Clk = 1'b0;
  logic                Rst = 1'b1;
  logic [7:0]          Integration_count = 8'd1;
  fft_control_t        Input_control = '0;
  logic signed [W-1:0] Input_i = '0;
  logic signed [W-1:0] Input_q = '0;
  fft_control_t        Output_control;
  logic [AW-1:0]       Output_power;
  logic                Error_sequence;

  fft_power_integrator dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Integration_count(Integration_count),
    .Input_control    (Input_control),
    .Input_i          (Input_i),
    .Input_q          (Input_q),
    .Output_control   (Output_control),
    .Output_power     (Output_power),
    .Error_sequence   (Error_sequence)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int     cyc;
    int     idx;
    bit     last;
    bit     rev;
    int     tag;
    longint power;
  } exp_t;

  exp_t   exp_q[$];
  int     err_q[$];
  exp_t   mon_e;
  int     mon_err;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  logic   rst_q    = 1'b0;

  int     m_exp    = 0;
  int     m_frame  = 0;
  int     m_target = 1;
  longint m_acc[N];

  int     fr_i[N];
  int     fr_q[N];

  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    rst_q <= Rst;
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic longint combine(input longint a, input longint b);
    longint s;
    s = a + b;
`ifdef FFT_POWER_INTEGRATOR_SATURATE_EN
    if (s > ACC_MAX) s = ACC_MAX;
`else
    s = s % ACC_MOD;
`endif
    return s;
  endfunction

  // Reference model. It applies the integration rules to one accepted sample.
  task automatic model_sample(input int idx, input bit last, input bit rev, input int tag,
                              input int i, input int q, input int issue);
    longint p;
    exp_t   e;
    if (idx != m_exp || last != (idx == N-1)) begin
      err_q.push_back(issue + 1);
      m_exp   = 0;
      m_frame = 0;
      return;
    end
    if (m_exp == 0 && m_frame == 0)
      m_target = (Integration_count == 0) ? 1 : int'(Integration_count);
    p = longint'(i) * longint'(i) + longint'(q) * longint'(q);
    m_acc[idx] = (m_frame == 0) ? p : combine(m_acc[idx], p);
    if (m_frame + 1 >= m_target) begin
      e.cyc   = issue + 4;
      e.idx   = idx;
      e.last  = last;
      e.rev   = rev;
      e.tag   = tag & 255;
      e.power = m_acc[idx];
      exp_q.push_back(e);
    end
    m_exp = (idx == N-1) ? 0 : idx + 1;
    if (last) m_frame = (m_frame + 1 < m_target) ? m_frame + 1 : 0;
  endtask

  task automatic apply_stimulus(input int idx, input bit last, input bit rev, input int tag,
                                input int i, input int q);
    @(posedge Clk); #1;
    Input_control.valid      = 1'b1;
    Input_control.last       = last;
    Input_control.reverse    = rev;
    Input_control.data_index = idx[4:0];
    Input_control.tag        = tag[7:0];
    Input_i                  = i[W-1:0];
    Input_q                  = q[W-1:0];
    model_sample(idx, last, rev, tag, i, q, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
      Input_control = '0;
      Input_i       = '0;
      Input_q       = '0;
    end
  endtask

  task automatic send_frame(input int tag, input bit rev, input int gap_max);
    for (int k = 0; k < N; k++) begin
      apply_stimulus(k, k == N-1, rev, tag, fr_i[k], fr_q[k]);
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      fr_i[k] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
      fr_q[k] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) begin
      fr_i[k] = k;
      fr_q[k] = -k;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge Clk); #1;
    Rst           = 1'b1;
    Input_control = '0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) mon_e = exp_q.pop_back();
    while (err_q.size() > 0 && err_q[$] > cyc) mon_err = err_q.pop_back();
    m_exp   = 0;
    m_frame = 0;
    repeat (n) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && (exp_q.size() > 0 || err_q.size() > 0); c++) @(posedge Clk);
    idle(2);
  endtask

  // Monitor: compares DUT outputs with the scoreboard, away from the active edge
  always @(negedge Clk) begin
    if (rst_q === 1'b1) begin
      check_output("reset_control", longint'(Output_control), 0);
      check_output("reset_power", longint'(Output_power), 0);
      check_output("reset_error", longint'(Error_sequence), 0);
    end else begin
      if (Output_control.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_output_valid", longint'(Output_control.valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("out_cycle", cyc, mon_e.cyc);
          check_output("out_index", longint'(Output_control.data_index), mon_e.idx);
          check_output("out_last", longint'(Output_control.last), mon_e.last);
          check_output("out_reverse", longint'(Output_control.reverse), mon_e.rev);
          check_output("out_tag", longint'(Output_control.tag), mon_e.tag);
          check_output("out_power", longint'(Output_power), mon_e.power);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        check_output("output_missing_valid", longint'(Output_control.valid), 1);
      end
      if (Error_sequence === 1'b1) begin
        if (err_q.size() == 0) begin
          check_output("unexpected_error", longint'(Error_sequence), 0);
        end else begin
          mon_err = err_q.pop_front();
          check_output("error_cycle", cyc, mon_err);
        end
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        mon_err = err_q.pop_front();
        check_output("error_missing", longint'(Error_sequence), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    repeat (5) @(posedge Clk);
    #1;
    Rst = 1'b0;

    $display("[TB] count 1, single frame");
    Integration_count = 8'd1;
    for (int k = 0; k < N; k++) begin fr_i[k] = 3; fr_q[k] = 4; end
    send_frame(8'h5A, 1'b0, 0);
    idle(6);

    $display("[TB] count 4, multi-frame");
    Integration_count = 8'd4;
    fill_ramp();
    for (int f = 1; f <= 4; f++) send_frame(f, 1'b1, 0);
    idle(6);

    $display("[TB] count 4 with random gaps");
    for (int f = 1; f <= 4; f++) begin
      send_frame(f, 1'b1, 5);
      idle(int'($urandom_range(0, 64)));
    end
    idle(6);

    $display("[TB] sequence error");
    Integration_count = 8'd2;
    fill_random();
    send_frame(8'h11, 1'b0, 0);
    for (int k = 0; k <= 5; k++) apply_stimulus(k, 1'b0, 1'b0, 8'h12, fr_i[k], fr_q[k]);
    apply_stimulus(7, 1'b0, 1'b0, 8'h12, fr_i[7], fr_q[7]);
    idle(3);
    fill_random();
    send_frame(8'h21, 1'b0, 2);
    fill_random();
    send_frame(8'h22, 1'b1, 2);
    idle(6);
    Integration_count = 8'd1;
    apply_stimulus(0, 1'b1, 1'b0, 8'h30, 1, 1);
    idle(3);
    send_frame(8'h31, 1'b0, 0);
    idle(6);

    $display("[TB] random periods with mid-period count changes");
    for (int p = 0; p < 4; p++) begin
      Integration_count = 8'($urandom_range(0, 3));
      for (int f = 0; f < 3; f++) begin
        fill_random();
        send_frame(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);
        Integration_count = 8'($urandom_range(0, 3));
      end
      idle(int'($urandom_range(0, 10)));
    end
    idle(6);
    // Force a clean period boundary before the next scenario
    do_reset(2);

    $display("[TB] reset mid-integration");
    Integration_count = 8'd3;
    fill_random();
    send_frame(8'h41, 1'b0, 0);
    for (int k = 0; k < 10; k++) apply_stimulus(k, 1'b0, 1'b0, 8'h42, fr_i[k], fr_q[k]);
    do_reset(10);
    apply_stimulus(3, 1'b0, 1'b0, 8'h43, 5, 5);
    idle(3);
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(8'h50 + f, 1'b1, 0);
    end
    idle(6);

    $display("[TB] large-value accumulation over 255 frames");
    Integration_count = 8'd255;
    for (int k = 0; k < N; k++) begin fr_i[k] = -(1 << 20); fr_q[k] = -(1 << 20); end
    for (int f = 0; f < 255; f++) send_frame(f, 1'b0, 0);
    idle(6);

    drain();
    check_output("pending_outputs", exp_q.size(), 0);
    check_output("pending_errors", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
